ac_coeff_scan_sequencer: RTL and testbench
==========================================

Name: ac_coeff_scan_sequencer

Overview:
- Sequences one slice of quantised coefficients out of the slice coefficient buffer into the AC VLC path.
- Walks AC scan positions 1..63 and, for each position, every block of the slice in order (ProRes interleaved AC order).
- Drives the AC level encoder's start/valid/end/Coeff stream and emits zero-run lengths for the AC run encoder.
- Sits between the quantiser output buffer and entropy_encode_ac_level_coefficients / run encoder.

Parameters:
- MAX_BLOCKS, 32, maximum blocks per slice (8 macroblocks x 4 luma blocks).
- ADDR_W, 11, buffer address width; must equal log2(MAX_BLOCKS*64).
- RUN_W, 11, run_length width; covers the maximum run of 63*MAX_BLOCKS-1 = 2015.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- slice_start  in  1  one-cycle request to sequence a slice.
- num_blocks  in  6  blocks in the slice; sampled on an accepted slice_start.
- busy  out  1  slice in progress.
- done  out  1  one-cycle pulse after the last element is emitted.
- coef_rd_en  out  1  buffer read strobe.
- coef_rd_addr  out  ADDR_W  read address = block*64 + scan_pos.
- coef_rd_data  in  32  signed coefficient; valid exactly 1 cycle after coef_rd_en.
- out_start  out  1  first scanned element of the slice.
- out_valid  out  1  element present on out_coeff.
- out_end  out  1  last scanned element of the slice.
- out_coeff  out  32  signed coefficient to the level encoder.
- run_valid  out  1  run_length is valid; coincides with a nonzero out_coeff.
- run_length  out  RUN_W  number of zero elements preceding this nonzero element.

Behaviour:
- Reset values: every output 0; FSM in IDLE; all counters 0.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - slice_start with 1 <= num_blocks <= MAX_BLOCKS latches num_blocks, clears idx to 1 and blk to 0, and moves to READ.
  - An out-of-range num_blocks (including 0) is ignored; the FSM stays in IDLE.
- READ:
  - coef_rd_en is 1 every cycle with addr = blk*64 + scan[idx].
  - blk increments each cycle; on wrap to 0, idx increments.
  - After issuing idx=63, blk=num_blocks-1, move to DRAIN.
- DRAIN: waits 2 cycles for the pipeline to empty, then moves to DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy = 1 in READ, DRAIN and DONE.
- slice_start while busy is ignored. There is no queueing.
- Latency: rd_en at cycle t -> data at t+1 -> out_* registered at t+2.
- Output stream:
  - out_valid is 1 for every scanned element, zeros included: exactly 63*num_blocks consecutive cycles, no bubbles.
  - out_start is high with the first element only; out_end is high with the last element only.
  - For num_blocks=1 and 63 elements, start and end are on different cycles.
- Runs:
  - zero_cnt increments on each zero element.
  - On a nonzero element: run_valid=1, run_length=zero_cnt, and zero_cnt clears.
  - Trailing zeros after the last nonzero produce no run_valid.
  - zero_cnt clears at slice start.
- Widths:
  - blk*64 is a shift.
  - run_length saturates at 2^RUN_W-1; unreachable within parameter limits, checked by assertion.
- Asynchronous reset mid-slice returns to IDLE immediately with all outputs 0. Downstream sees no out_end.

Optional Feature:
- SCAN_INTERLACED_EN
  - Defined: adds input scan_sel (1 bit, sampled with slice_start). scan_sel=1 uses the ProRes interlaced scan table; 0 uses progressive.
  - Undefined: no scan_sel port; the progressive table only.

Decomposition:
- Package prores_vlc_pkg:
  - progressive and interlaced 64-entry scan tables (6-bit entries);
  - FSM state typedef;
  - constants BLK_COEFFS=64 and FIRST_AC_IDX=1.
- Sub-module scan_order_rom: combinational lookup scan[idx], with a table select input under SCAN_INTERLACED_EN.

Test Plan:
- num_blocks=1, buffer holds address k = k -> 63 reads with addr=scan[1..63]; out_coeff follows the same sequence; start on element 0, end on element 62; done 1 cycle after end; run_valid on every element with run_length=0.
- num_blocks=4, all-zero buffer except block 2 scan[1]=5 and block 0 scan[2]=-3 -> 252 valid cycles; run_valid twice: run_length=2 at element 2 and run_length=1 at element 4; no trailing run.
- slice_start asserted again during busy and with num_blocks=0 -> both ignored; a single done; busy timing unchanged.
- Back-to-back: a second slice_start the cycle after done (num_blocks=32) -> 2016 contiguous valid cycles; run counter starts fresh at 0.
- reset_n pulled low at element 100 of a 32-block slice -> all outputs 0 asynchronously; a following slice_start sequences correctly from idx 1.
- SCAN_INTERLACED_EN with scan_sel=1 -> read addresses follow the interlaced table; scan_sel=0 matches the progressive golden output bit-exactly.

Source files
------------

// File: rtl/prores_vlc_pkg.sv
// Shared types and scan tables for the ProRes AC VLC path.
// Holds the progressive/interlaced scan orders and the sequencer FSM type.
package prores_vlc_pkg;

  localparam int BLK_COEFFS   = 64;
  localparam int FIRST_AC_IDX = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  localparam logic [5:0] SCAN_PROG [64] = '{
    6'd0,  6'd1,  6'd8,  6'd9,  6'd2,  6'd3,  6'd10, 6'd11,
    6'd16, 6'd17, 6'd24, 6'd25, 6'd18, 6'd19, 6'd26, 6'd27,
    6'd4,  6'd5,  6'd12, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14,
    6'd21, 6'd28, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd31,
    6'd32, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd35, 6'd42,
    6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36, 6'd37, 6'd44,
    6'd51, 6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  localparam logic [5:0] SCAN_ILACE [64] = '{
    6'd0,  6'd8,  6'd1,  6'd9,  6'd16, 6'd24, 6'd17, 6'd25,
    6'd2,  6'd10, 6'd3,  6'd11, 6'd18, 6'd26, 6'd19, 6'd27,
    6'd32, 6'd40, 6'd33, 6'd34, 6'd41, 6'd48, 6'd56, 6'd49,
    6'd42, 6'd35, 6'd43, 6'd50, 6'd57, 6'd58, 6'd51, 6'd59,
    6'd4,  6'd12, 6'd5,  6'd6,  6'd13, 6'd20, 6'd28, 6'd21,
    6'd14, 6'd7,  6'd15, 6'd22, 6'd29, 6'd36, 6'd44, 6'd37,
    6'd30, 6'd23, 6'd31, 6'd38, 6'd45, 6'd52, 6'd60, 6'd53,
    6'd46, 6'd39, 6'd47, 6'd54, 6'd61, 6'd62, 6'd55, 6'd63
  };

  function automatic logic [5:0] scan_pos(
    input logic       sel,
    input logic [5:0] idx
  );
    return sel ? SCAN_ILACE[idx] : SCAN_PROG[idx];
  endfunction

endpackage

// File: rtl/scan_order_rom.sv
// Combinational scan-order lookup: scan index -> raster position.
// SCAN_INTERLACED_EN adds a table select; otherwise progressive only.
module scan_order_rom
  import prores_vlc_pkg::*;
(
`ifdef SCAN_INTERLACED_EN
  input  logic       scan_sel_i,
`endif
  input  logic [5:0] idx_i,
  output logic [5:0] pos_o
);

  // Pick the raster position for the current scan index
  always_comb begin
`ifdef SCAN_INTERLACED_EN
    pos_o = scan_pos(scan_sel_i, idx_i);
`else
    pos_o = scan_pos(1'b0, idx_i);
`endif
  end

endmodule

// File: rtl/ac_coeff_scan_sequencer.sv
// Streams a slice's AC coefficients in interleaved scan order with runs.
// Optional macro SCAN_INTERLACED_EN adds the scan_sel input.
module ac_coeff_scan_sequencer
  import prores_vlc_pkg::*;
#(
  parameter int MAX_BLOCKS = 32,
  parameter int ADDR_W     = 11,
  parameter int RUN_W      = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              slice_start,
  input  logic [5:0]        num_blocks,
`ifdef SCAN_INTERLACED_EN
  input  logic              scan_sel,
`endif
  output logic              busy,
  output logic              done,
  output logic              coef_rd_en,
  output logic [ADDR_W-1:0] coef_rd_addr,
  input  logic [31:0]       coef_rd_data,
  output logic              out_start,
  output logic              out_valid,
  output logic              out_end,
  output logic [31:0]       out_coeff,
  output logic              run_valid,
  output logic [RUN_W-1:0]  run_length
);

  localparam int         POS_W     = $clog2(BLK_COEFFS);
  localparam logic [6:0] MAXB      = 7'(MAX_BLOCKS);
  localparam logic [5:0] LAST_IDX  = 6'(BLK_COEFFS - 1);
  localparam logic [5:0] FIRST_IDX = 6'(FIRST_AC_IDX);

  seq_state_e state_q, state_d;
  logic       drain_q, drain_d;
  logic [5:0] nb_q, nb_d;
  logic [5:0] blk_q, blk_d;
  logic [5:0] idx_q, idx_d;

  logic [POS_W-1:0] pos;
  logic             accept;
  logic             start_ok;
  logic             last_blk;
  logic             last_idx;

  logic p1_v_q;
  logic p1_first_q;
  logic p1_last_q;

  logic [RUN_W-1:0] zero_cnt_q, zero_cnt_d;
  logic             rv_d;
  logic [RUN_W-1:0] rl_d;

  logic             out_start_q;
  logic             out_valid_q;
  logic             out_end_q;
  logic [31:0]      out_coeff_q;
  logic             run_valid_q;
  logic [RUN_W-1:0] run_length_q;

`ifdef SCAN_INTERLACED_EN
  logic sel_q, sel_d;

  scan_order_rom u_rom (
    .scan_sel_i (sel_q),
    .idx_i      (idx_q),
    .pos_o      (pos)
  );
`else
  scan_order_rom u_rom (
    .idx_i (idx_q),
    .pos_o (pos)
  );
`endif

  assign accept = slice_start
                & (num_blocks != 6'd0)
                & ({1'b0, num_blocks} <= MAXB);
  assign start_ok = (state_q == ST_IDLE) & accept;
  assign last_blk = (blk_q == nb_q - 6'd1);
  assign last_idx = (idx_q == LAST_IDX);

  // FSM state and walk counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      drain_q <= 1'b0;
      nb_q    <= '0;
      blk_q   <= '0;
      idx_q   <= '0;
`ifdef SCAN_INTERLACED_EN
      sel_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      nb_q    <= nb_d;
      blk_q   <= blk_d;
      idx_q   <= idx_d;
`ifdef SCAN_INTERLACED_EN
      sel_q   <= sel_d;
`endif
    end
  end

  // Next state: walk blocks fastest, then scan index
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    nb_d    = nb_q;
    blk_d   = blk_q;
    idx_d   = idx_q;
`ifdef SCAN_INTERLACED_EN
    sel_d   = sel_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          nb_d    = num_blocks;
          blk_d   = '0;
          idx_d   = FIRST_IDX;
          state_d = ST_READ;
`ifdef SCAN_INTERLACED_EN
          sel_d   = scan_sel;
`endif
        end
      end
      ST_READ: begin
        if (last_blk) begin
          blk_d = '0;
          if (last_idx) begin
            idx_d   = '0;
            drain_d = 1'b0;
            state_d = ST_DRAIN;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end else begin
          blk_d = blk_q + 6'd1;
        end
      end
      ST_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          drain_d = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM-decoded outputs
  always_comb begin
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_DONE);
    coef_rd_en   = (state_q == ST_READ);
    coef_rd_addr = ADDR_W'({blk_q, pos});
  end

  // Tags travelling alongside the outstanding read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_v_q     <= 1'b0;
      p1_first_q <= 1'b0;
      p1_last_q  <= 1'b0;
    end else begin
      p1_v_q     <= coef_rd_en;
      p1_first_q <= coef_rd_en & (idx_q == FIRST_IDX)
                  & (blk_q == 6'd0);
      p1_last_q  <= coef_rd_en & last_idx & last_blk;
    end
  end

  // Zero-run accounting on the returning data
  always_comb begin
    zero_cnt_d = zero_cnt_q;
    rv_d       = 1'b0;
    rl_d       = '0;
    if (start_ok) begin
      zero_cnt_d = '0;
    end else if (p1_v_q) begin
      if (coef_rd_data == '0) begin
        if (zero_cnt_q != '1)
          zero_cnt_d = zero_cnt_q + RUN_W'(1);
      end else begin
        rv_d       = 1'b1;
        rl_d       = zero_cnt_q;
        zero_cnt_d = '0;
      end
    end
  end

  // Registered element and run outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_cnt_q   <= '0;
      out_start_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_end_q    <= 1'b0;
      out_coeff_q  <= '0;
      run_valid_q  <= 1'b0;
      run_length_q <= '0;
    end else begin
      zero_cnt_q   <= zero_cnt_d;
      out_start_q  <= p1_v_q & p1_first_q;
      out_valid_q  <= p1_v_q;
      out_end_q    <= p1_v_q & p1_last_q;
      out_coeff_q  <= p1_v_q ? coef_rd_data : '0;
      run_valid_q  <= rv_d;
      run_length_q <= rl_d;
    end
  end

  assign out_start  = out_start_q;
  assign out_valid  = out_valid_q;
  assign out_end    = out_end_q;
  assign out_coeff  = out_coeff_q;
  assign run_valid  = run_valid_q;
  assign run_length = run_length_q;

  // Run counter never reaches its ceiling for legal slice sizes
  a_run_no_sat: assert property (
    @(posedge clk) disable iff (!reset_n) zero_cnt_q != '1
  );

endmodule

// File: tb/tb_ac_coeff_scan_sequencer.sv
// Self-checking bench for ac_coeff_scan_sequencer.
// Table vectors, random slices and hand-written corner sequences.
`timescale 1ns/1ps
module tb_ac_coeff_scan_sequencer;

  localparam int AW = 11;
  localparam int RW = 11;

  localparam int PS [64] = '{
    0, 1, 8, 9, 2, 3, 10, 11, 16, 17, 24, 25, 18, 19, 26, 27,
    4, 5, 12, 20, 13, 6, 7, 14, 21, 28, 29, 22, 15, 23, 30, 31,
    32, 33, 40, 48, 41, 34, 35, 42, 49, 56, 57, 50, 43, 36, 37, 44,
    51, 58, 59, 52, 45, 38, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };
  localparam int IS [64] = '{
    0, 8, 1, 9, 16, 24, 17, 25, 2, 10, 3, 11, 18, 26, 19, 27,
    32, 40, 33, 34, 41, 48, 56, 49, 42, 35, 43, 50, 57, 58, 51, 59,
    4, 12, 5, 6, 13, 20, 28, 21, 14, 7, 15, 22, 29, 36, 44, 37,
    30, 23, 31, 38, 45, 52, 60, 53, 46, 39, 47, 54, 61, 62, 55, 63
  };

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          slice_start = 1'b0;
  logic [5:0]    num_blocks = '0;
`ifdef SCAN_INTERLACED_EN
  logic          scan_sel = 1'b0;
`endif
  logic          busy, done, coef_rd_en;
  logic [AW-1:0] coef_rd_addr;
  logic [31:0]   coef_rd_data = '0;
  logic          out_start, out_valid, out_end;
  logic [31:0]   out_coeff;
  logic          run_valid;
  logic [RW-1:0] run_length;

  always #5 clk = ~clk;

  ac_coeff_scan_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .slice_start  (slice_start),
    .num_blocks   (num_blocks),
`ifdef SCAN_INTERLACED_EN
    .scan_sel     (scan_sel),
`endif
    .busy         (busy),
    .done         (done),
    .coef_rd_en   (coef_rd_en),
    .coef_rd_addr (coef_rd_addr),
    .coef_rd_data (coef_rd_data),
    .out_start    (out_start),
    .out_valid    (out_valid),
    .out_end      (out_end),
    .out_coeff    (out_coeff),
    .run_valid    (run_valid),
    .run_length   (run_length)
  );

  logic [31:0] mem [2048];

  always @(posedge clk)
    if (coef_rd_en) coef_rd_data <= mem[coef_rd_addr];

  typedef struct {
    int          cyc;
    logic [31:0] c;
    bit          s;
    bit          e;
    bit          rv;
    int          rl;
  } ob_t;

  ob_t obs[$];
  int  addrs[$];
  int  cyc = 0;
  int  rd0_cyc, done_cnt, done_cyc, end_cyc, end_cnt, busy_cnt, stray;
  bit  cur_sel = 1'b0;
  int  n_vec = 0;
  int  n_fail = 0;

  always @(negedge clk) begin
    cyc++;
    if (out_valid)
      obs.push_back('{cyc, out_coeff, out_start, out_end,
                      run_valid, int'(run_length)});
    else if (out_start || out_end || run_valid)
      stray++;
    if (out_end) begin end_cnt++; end_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_cnt++;
    if (coef_rd_en) begin
      if (addrs.size() == 0) rd0_cyc = cyc;
      addrs.push_back(int'(coef_rd_addr));
    end
  end

  function automatic int scan(input bit sel, input int i);
    return sel ? IS[i] : PS[i];
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    obs.delete();
    addrs.delete();
    rd0_cyc = -1; done_cnt = 0; done_cyc = -1;
    end_cyc = -1; end_cnt = 0; busy_cnt = 0; stray = 0;
  endtask

  task automatic fill(input int pat);
    for (int k = 0; k < 2048; k++) begin
      case (pat)
        0: mem[k] = 32'(k);
        3: mem[k] = ($urandom_range(0, 3) == 0) ? 32'd0 :
                    32'($urandom_range(0, 4000)) - 32'd2000;
        4: mem[k] = ($urandom_range(0, 39) == 0) ?
                    (32'($urandom) | 32'd1) : 32'd0;
        default: mem[k] = 32'd0;
      endcase
    end
    if (pat == 1) begin
      mem[2*64 + PS[1]] = 32'd5;
      mem[PS[2]]        = -32'sd3;
    end
    if (pat == 5) mem[3*64 + PS[5]] = 32'd11;
  endtask

  task automatic launch(input int nb, input bit sel);
    @(posedge clk); #1;
    clear_mon();
    cur_sel = sel;
    slice_start = 1'b1;
    num_blocks = 6'(nb);
`ifdef SCAN_INTERLACED_EN
    scan_sel = sel;
`endif
    @(posedge clk); #1;
    slice_start = 1'b0;
  endtask

  task automatic check_stream(input int nb, output int nr);
    int ea[$];
    logic [31:0] ec[$];
    int erl[$];
    int z, a, n, ba, bc, bs, be, br, bg;
    z = 0;
    for (int i = 1; i < 64; i++)
      for (int b = 0; b < nb; b++) begin
        a = b * 64 + scan(cur_sel, i);
        ea.push_back(a);
        ec.push_back(mem[a]);
        if (mem[a] == 0) begin z++; erl.push_back(-1); end
        else begin erl.push_back(z); z = 0; end
      end
    chk("rd_count", addrs.size(), ea.size());
    ba = 0;
    n = (addrs.size() < ea.size()) ? addrs.size() : ea.size();
    for (int k = 0; k < n; k++) if (addrs[k] != ea[k]) ba++;
    chk("addr_stream_bad", ba, 0);
    chk("valid_count", obs.size(), ec.size());
    n = (obs.size() < ec.size()) ? obs.size() : ec.size();
    bc = 0; bs = 0; be = 0; br = 0; bg = 0; nr = 0;
    for (int k = 0; k < n; k++) begin
      if (obs[k].c !== ec[k]) begin
        if (bc == 0)
          $display("  elem %0d coeff %0d want %0d", k,
                   $signed(obs[k].c), $signed(ec[k]));
        bc++;
      end
      if (obs[k].s != (k == 0)) bs++;
      if (obs[k].e != (k == ec.size() - 1)) be++;
      if (obs[k].rv != (erl[k] >= 0)) br++;
      else if (obs[k].rv && obs[k].rl != erl[k]) br++;
      if (obs[k].cyc != obs[0].cyc + k) bg++;
      if (obs[k].rv) nr++;
    end
    chk("coeff_stream_bad", bc, 0);
    chk("start_flag_bad", bs, 0);
    chk("end_flag_bad", be, 0);
    chk("run_stream_bad", br, 0);
    chk("valid_gaps", bg, 0);
    chk("stray_flags", stray, 0);
    chk("rd_to_out_latency",
        obs.size() > 0 ? obs[0].cyc - rd0_cyc : -1, 2);
    chk("end_pulses", end_cnt, 1);
    chk("done_after_end", done_cyc - end_cyc, 1);
    chk("busy_cycles", busy_cnt, 63 * nb + 3);
  endtask

  task automatic finish(input int nb, input bit settle, output int nr);
    int c;
    c = 0;
    while (done_cnt == 0 && c < 3000) begin
      @(negedge clk); #1;
      c++;
    end
    if (done_cnt == 0) $display("FAIL done_timeout: no done seen");
    if (settle) begin
      repeat (4) @(negedge clk);
      #1;
    end
    chk("done_pulses", done_cnt, 1);
    check_stream(nb, nr);
  endtask

  typedef struct {
    int nb;
    int pat;
    int ev;
    int er;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int nr, c, nb;
    int ri[$];
    int rl[$];
    logic [31:0] rc[$];

    tbl[0] = '{1, 0, 63, 63};
    tbl[1] = '{2, 0, 126, 126};
    tbl[2] = '{32, 2, 2016, 0};
    tbl[3] = '{7, 3, 441, -1};
    tbl[4] = '{32, 4, 2016, -1};
    tbl[5] = '{4, 1, 252, 2};

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", coef_rd_en, 0);
    chk("rst_rd_addr", coef_rd_addr, 0);
    chk("rst_flags", {out_start, out_valid, out_end, run_valid}, 0);
    chk("rst_coeff", out_coeff, 0);
    chk("rst_run_len", run_length, 0);
    reset_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      fill(tbl[v].pat);
      launch(tbl[v].nb, 1'b0);
      finish(tbl[v].nb, 1'b1, nr);
      chk($sformatf("vec%0d_valid", v), obs.size(), tbl[v].ev);
      if (tbl[v].er >= 0)
        chk($sformatf("vec%0d_runs", v), nr, tbl[v].er);
    end

    fill(1);
    launch(4, 1'b0);
    finish(4, 1'b1, nr);
    foreach (obs[k])
      if (obs[k].rv) begin
        ri.push_back(k); rl.push_back(obs[k].rl); rc.push_back(obs[k].c);
      end
    chk("sparse_run_count", ri.size(), 2);
    if (ri.size() == 2) begin
      chk("sparse_run0_idx", ri[0], 2);
      chk("sparse_run0_len", rl[0], 2);
      chk("sparse_run0_coef", $signed(rc[0]), 5);
      chk("sparse_run1_idx", ri[1], 4);
      chk("sparse_run1_len", rl[1], 1);
      chk("sparse_run1_coef", $signed(rc[1]), -3);
    end

    @(posedge clk); #1;
    clear_mon();
    slice_start = 1'b1; num_blocks = 6'd0;
    @(posedge clk); #1;
    num_blocks = 6'd33;
    @(posedge clk); #1;
    slice_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_ignore_busy", busy_cnt, 0);
    chk("idle_ignore_reads", addrs.size(), 0);

    fill(3);
    launch(3, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    slice_start = 1'b1; num_blocks = 6'd5;
    @(posedge clk); #1;
    num_blocks = 6'd0;
    @(posedge clk); #1;
    slice_start = 1'b0;
    finish(3, 1'b1, nr);

    fill(5);
    launch(32, 1'b0);
    finish(32, 1'b0, nr);
    launch(32, 1'b0);
    finish(32, 1'b1, nr);
    chk("b2b_runs", nr, 1);
    foreach (obs[k])
      if (obs[k].rv) chk("b2b_run_len", obs[k].rl, 131);

    fill(0);
    launch(32, 1'b0);
    c = 0;
    while (obs.size() < 101 && c < 500) begin
      @(negedge clk); #1;
      c++;
    end
    chk("mid_reached_elem100", obs.size(), 101);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_en", coef_rd_en, 0);
    chk("mid_rst_flags", {out_start, out_valid, out_end, run_valid, done}, 0);
    chk("mid_rst_coeff", out_coeff, 0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_rst_no_end", end_cnt, 0);
    chk("mid_rst_no_done", done_cnt, 0);
    launch(32, 1'b0);
    finish(32, 1'b1, nr);

`ifdef SCAN_INTERLACED_EN
    fill(0);
    launch(3, 1'b1);
    finish(3, 1'b1, nr);
    launch(3, 1'b0);
    finish(3, 1'b1, nr);
`endif

    for (int r = 0; r < 6; r++) begin
      nb = $urandom_range(1, 32);
      fill($urandom_range(3, 4));
      launch(nb, 1'b0);
      finish(nb, 1'b1, nr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
